// File: rtl/reset_seq_gen.sv
// Sequenced active-low reset generator for the user-area subsystems.
// All outputs are held low for HOLD_CYCLES after a restart. They are then
// released one at a time, index 0 first, STAGGER cycles apart. A software
// request or a watchdog expiry re-runs the sequence, and the cause of the
// most recent sequence is kept in reset_cause.
module reset_seq_gen #(
  parameter int NUM_OUTS    = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGGER     = 4,
  parameter int WDT_LIMIT   = 100,
  parameter int CNT_W       = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                soft_reset_req,
  input  logic                wdt_enable,
  input  logic                wdt_kick,
  output logic [NUM_OUTS-1:0] rst_n,
  output logic                busy,
  output logic [1:0]          reset_cause,
  output logic [CNT_W-1:0]    wdt_count
);

  localparam int IDX_W = (NUM_OUTS > 1) ? $clog2(NUM_OUTS) : 1;

  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_SOFT = 2'b01;
  localparam logic [1:0] CAUSE_WDT  = 2'b10;

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_RELEASE,
    ST_RUN
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [NUM_OUTS-1:0] rst_n_q, rst_n_d;
  logic                busy_q, busy_d;
  logic [1:0]          cause_q, cause_d;
  logic [CNT_W-1:0]    wdt_q, wdt_d;

  logic [CNT_W-1:0]    cnt_inc;
  logic                wdt_expire;

  assign cnt_inc = cnt_q + CNT_W'(1);

  // Expiry needs an armed watchdog in RUN, no kick this cycle, and the count at its last value.
  assign wdt_expire = (state_q == ST_RUN) && wdt_enable && !wdt_kick &&
                      (wdt_q == CNT_W'(WDT_LIMIT - 1));

  // Next-state logic: a restart (soft request or expiry) overrides the normal sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_n_d = rst_n_q;
    busy_d  = busy_q;
    cause_d = cause_q;
    wdt_d   = '0;

    if (soft_reset_req || wdt_expire) begin
      // A soft request takes precedence when both happen on the same edge.
      state_d = ST_ASSERT;
      cnt_d   = '0;
      idx_d   = '0;
      rst_n_d = '0;
      busy_d  = 1'b1;
      cause_d = soft_reset_req ? CAUSE_SOFT : CAUSE_WDT;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          if (cnt_inc == CNT_W'(HOLD_CYCLES)) begin
            rst_n_d[0] = 1'b1;
            cnt_d      = '0;
            idx_d      = IDX_W'(1);
            if (NUM_OUTS == 1) begin
              state_d = ST_RUN;
              busy_d  = 1'b0;
            end else begin
              state_d = ST_RELEASE;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_RELEASE: begin
          if (cnt_inc == CNT_W'(STAGGER)) begin
            rst_n_d[idx_q] = 1'b1;
            cnt_d          = '0;
            idx_d          = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(NUM_OUTS - 1)) begin
              state_d = ST_RUN;
              busy_d  = 1'b0;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_RUN: begin
          // The watchdog only counts here; it is zero in every other state.
          if (wdt_enable) begin
            wdt_d = wdt_kick ? '0 : (wdt_q + CNT_W'(1));
          end
        end
        default: begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
          idx_d   = '0;
          rst_n_d = '0;
          busy_d  = 1'b1;
        end
      endcase
    end
  end

  // State and output registers; reset overrides every other input.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_n_q <= '0;
      busy_q  <= 1'b1;
      cause_q <= CAUSE_POR;
      wdt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_n_q <= rst_n_d;
      busy_q  <= busy_d;
      cause_q <= cause_d;
      wdt_q   <= wdt_d;
    end
  end

  assign rst_n       = rst_n_q;
  assign busy        = busy_q;
  assign reset_cause = cause_q;
  assign wdt_count   = wdt_q;

endmodule

// File: tb/tb_reset_seq_gen.sv
// Directed testbench for reset_seq_gen using the default parameters
// (4 outputs, hold 16, stagger 4, watchdog limit 100).
module tb_reset_seq_gen;

  logic        clock;
  logic        reset;
  logic        soft_reset_req;
  logic        wdt_enable;
  logic        wdt_kick;
  logic [3:0]  rst_n;
  logic        busy;
  logic [1:0]  reset_cause;
  logic [15:0] wdt_count;

  int n_checks = 0;
  int n_errors = 0;

  reset_seq_gen #(
    .NUM_OUTS    (4),
    .HOLD_CYCLES (16),
    .STAGGER     (4),
    .WDT_LIMIT   (100),
    .CNT_W       (16)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .soft_reset_req (soft_reset_req),
    .wdt_enable     (wdt_enable),
    .wdt_kick       (wdt_kick),
    .rst_n          (rst_n),
    .busy           (busy),
    .reset_cause    (reset_cause),
    .wdt_count      (wdt_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [3:0] e_rst, input logic e_busy,
                            input logic [1:0] e_cause);
    check({tag, ".rst_n"}, 32'(rst_n), 32'(e_rst));
    check({tag, ".busy"},  32'(busy),  32'(e_busy));
    check({tag, ".cause"}, 32'(reset_cause), 32'(e_cause));
  endtask

  initial begin
    reset          = 1'b1;
    soft_reset_req = 1'b0;
    wdt_enable     = 1'b0;
    wdt_kick       = 1'b0;

    // Power-on reset
    step(3);
    check_outs("por_hold", 4'b0000, 1'b1, 2'b00);
    check("por_wdt", 32'(wdt_count), 32'd0);
    reset = 1'b0;
    step(15);
    check_outs("por_e15", 4'b0000, 1'b1, 2'b00);
    step(1);
    check_outs("por_e16", 4'b0001, 1'b1, 2'b00);
    step(3);
    check_outs("por_e19", 4'b0001, 1'b1, 2'b00);
    step(1);
    check_outs("por_e20", 4'b0011, 1'b1, 2'b00);
    step(4);
    check_outs("por_e24", 4'b0111, 1'b1, 2'b00);
    step(3);
    check_outs("por_e27", 4'b0111, 1'b1, 2'b00);
    step(1);
    check_outs("por_e28", 4'b1111, 1'b0, 2'b00);
    step(5);
    check_outs("por_run", 4'b1111, 1'b0, 2'b00);

    // Soft request in RUN
    soft_reset_req = 1'b1;
    step(1);
    soft_reset_req = 1'b0;
    check_outs("soft_e0", 4'b0000, 1'b1, 2'b01);
    step(15);
    check_outs("soft_e15", 4'b0000, 1'b1, 2'b01);
    step(1);
    check_outs("soft_e16", 4'b0001, 1'b1, 2'b01);
    step(4);
    check_outs("soft_e20", 4'b0011, 1'b1, 2'b01);

    // Soft request mid-RELEASE with rst_n=0011
    soft_reset_req = 1'b1;
    step(1);
    soft_reset_req = 1'b0;
    check_outs("mid_e0", 4'b0000, 1'b1, 2'b01);
    step(4);
    check_outs("mid_e4", 4'b0000, 1'b1, 2'b01);
    step(11);
    check_outs("mid_e15", 4'b0000, 1'b1, 2'b01);
    step(1);
    check_outs("mid_e16", 4'b0001, 1'b1, 2'b01);
    step(12);
    check_outs("mid_e28", 4'b1111, 1'b0, 2'b01);

    // Watchdog expiry with no kicks
    wdt_enable = 1'b1;
    step(1);
    check("wdt_first", 32'(wdt_count), 32'd1);
    step(98);
    check("wdt_99", 32'(wdt_count), 32'd99);
    check_outs("wdt_pre", 4'b1111, 1'b0, 2'b01);
    step(1);
    check_outs("wdt_exp", 4'b0000, 1'b1, 2'b10);
    check("wdt_exp_cnt", 32'(wdt_count), 32'd0);
    step(5);
    check("wdt_hold_cnt", 32'(wdt_count), 32'd0);
    step(23);
    check_outs("wdt_rel", 4'b1111, 1'b0, 2'b10);
    check("wdt_rel_cnt", 32'(wdt_count), 32'd0);

    // Kick exactly at count 99 prevents expiry
    step(99);
    check("kick_pre", 32'(wdt_count), 32'd99);
    wdt_kick = 1'b1;
    step(1);
    wdt_kick = 1'b0;
    check("kick_cnt", 32'(wdt_count), 32'd0);
    check_outs("kick_outs", 4'b1111, 1'b0, 2'b10);
    step(5);
    check("kick_cnt5", 32'(wdt_count), 32'd5);
    wdt_enable = 1'b0;
    step(1);
    check("dis_cnt", 32'(wdt_count), 32'd0);
    step(3);
    check("dis_cnt3", 32'(wdt_count), 32'd0);

    // Soft request on the expiry cycle: one restart, soft wins
    wdt_enable = 1'b1;
    step(99);
    check("sim_pre", 32'(wdt_count), 32'd99);
    soft_reset_req = 1'b1;
    step(1);
    soft_reset_req = 1'b0;
    wdt_enable = 1'b0;
    check_outs("sim_e0", 4'b0000, 1'b1, 2'b01);
    check("sim_cnt", 32'(wdt_count), 32'd0);
    step(15);
    check_outs("sim_e15", 4'b0000, 1'b1, 2'b01);
    step(1);
    check_outs("sim_e16", 4'b0001, 1'b1, 2'b01);

    // Reset during RELEASE
    step(4);
    check_outs("rrel_e20", 4'b0011, 1'b1, 2'b01);
    reset = 1'b1;
    step(1);
    check_outs("rrel_rst", 4'b0000, 1'b1, 2'b00);
    reset = 1'b0;
    step(15);
    check_outs("rrel_e15", 4'b0000, 1'b1, 2'b00);
    step(1);
    check_outs("rrel_e16", 4'b0001, 1'b1, 2'b00);
    step(12);
    check_outs("rrel_e28", 4'b1111, 1'b0, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reset_seq_gen.md
Name: reset_seq_gen

Overview:
- Generates sequenced, active-low reset outputs for the user-area subsystems (SPI front end, actuator drivers, pattern engines).
- Each output goes to the `signal_n` input of a per-domain `sync_n` synchronizer, so this block is the source end of the reset path that `sync_n` consumes.
- Holds all resets asserted for a fixed time, then releases them one at a time in a staggered order.
- Re-runs the sequence on a software request or on watchdog expiry, and records the cause of the last reset.

Parameters:
- NUM_OUTS, 4, number of active-low reset outputs; released in index order 0 first.
- HOLD_CYCLES, 16, clock cycles that all outputs stay asserted before the first release (≥1).
- STAGGER, 4, clock cycles between consecutive output releases (≥1).
- WDT_LIMIT, 100, consecutive un-kicked enabled cycles that cause watchdog expiry (≥2).
- CNT_W, 16, width of the internal hold/stagger and watchdog counters; must hold max(HOLD_CYCLES, STAGGER, WDT_LIMIT).

Ports:
- clock  input  1  system clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- soft_reset_req  input  1  single-cycle software reset request.
- wdt_enable  input  1  level; 1 arms the watchdog.
- wdt_kick  input  1  single-cycle watchdog service pulse.
- rst_n  output  NUM_OUTS  active-low reset outputs, registered.
- busy  output  1  1 while the sequence is in progress (any rst_n bit low).
- reset_cause  output  2  cause of the last sequence: 00 POR, 01 SOFT, 10 WDT; 11 never driven.
- wdt_count  output  CNT_W  current watchdog count, for debug/status readback.

Behaviour:
- All outputs are registered. No combinational path from any input to any output.
- Reset (reset=1 at a clock edge): state=ASSERT, phase counter=0, rst_n=all 0, busy=1, reset_cause=00, wdt_count=0. Reset overrides every other input, including mid-sequence.
- States:
  - ASSERT: phase counter increments each edge. On the edge where it reaches HOLD_CYCLES: rst_n[0]<=1, counter<=0, release index<=1, go to RELEASE. If NUM_OUTS==1, go directly to RUN and busy<=0.
  - RELEASE: counter increments each edge. On the edge where it reaches STAGGER: rst_n[index]<=1, counter<=0, index++. On the edge that releases rst_n[NUM_OUTS-1]: go to RUN and busy<=0 on that same edge.
  - RUN: rst_n=all 1, busy=0, watchdog active.
- Release timing, counting edges after the first edge that samples reset=0 as edge 1: rst_n[i] goes high after edge HOLD_CYCLES + i*STAGGER. With the defaults, edges 16, 20, 24 and 28.
- Released bits stay 1 until the next sequence restart. Bits never glitch low outside a restart.
- soft_reset_req=1 in any non-reset state, including ASSERT and RELEASE, restarts the sequence on the next edge:
  - state<=ASSERT, counter<=0, rst_n<=all 0, busy<=1, reset_cause<=01.
- Watchdog:
  - wdt_count is forced to 0 when state≠RUN or wdt_enable=0.
  - In RUN with wdt_enable=1: wdt_kick=1 sets wdt_count<=0. Otherwise wdt_count increments.
  - If wdt_count==WDT_LIMIT-1 and it would increment, this is expiry. On that edge: restart as for a soft request, but reset_cause<=10 and wdt_count<=0.
  - wdt_kick has priority over expiry in the same cycle, so no expiry occurs.
- Simultaneous soft_reset_req and watchdog expiry: restart once, reset_cause=01 (soft wins).
- Counters saturate logic is not needed; every counter is cleared on state change. CNT_W overflow is impossible by parameter constraint.

Test Plan:
- POR: hold reset=1 for 3 cycles, then 0. rst_n=0000 through edge 15. Bit0 rises at edge 16, bit1 at 20, bit2 at 24, bit3 at 28. busy falls at edge 28. reset_cause=00.
- Soft request in RUN: pulse soft_reset_req. Next edge rst_n=0000, busy=1, reset_cause=01. Release pattern 16/20/24/28 edges after the request edge.
- Soft request mid-RELEASE, when rst_n=0011: all bits go low on the next edge and the full 16-cycle hold restarts. No bit releases early.
- Watchdog expiry: wdt_enable=1 with no kicks. wdt_count reaches 99, then the next edge restarts the sequence with reset_cause=10 and wdt_count=0.
- Kick at the boundary: kick when wdt_count=99. Count returns to 0 with no expiry. Dropping wdt_enable to 0 clears the count immediately.
- Reset mid-sequence and simultaneity:
  - Assert reset during RELEASE: outputs go 0000 and reset_cause=00.
  - Assert soft_reset_req on the expiry cycle: a single restart with reset_cause=01.
